// File: rtl/ibex_pkg.sv
// Shared types and constants for the custom I/O channel.
package ibex_pkg;

  localparam int CustNumAddr = 32;

  typedef logic [4:0]  cust_addr_t;
  typedef logic [31:0] cust_data_t;

endpackage

// File: rtl/ibex_cust_rr_arb.sv
// Round-robin picker: first eligible requester at or after ptr, wrapping mod NumReq.
module ibex_cust_rr_arb #(
  parameter  int NumReq = 4,
  localparam int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] eligible,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   gnt_idx,
  output logic              gnt_valid
);

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NumReq) s = s - NumReq;
    return IdxW'(s);
  endfunction

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!gnt_valid && eligible[wrap_idx(ptr, i)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = wrap_idx(ptr, i);
      end
    end
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/ibex_cust_io_arb.sv
// Arbitrates NumReq writers onto one custom input channel and routes responses
// back to the requester that owns each outstanding address.
module ibex_cust_io_arb import ibex_pkg::*; #(
  parameter int NumReq = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  cust_data_t [NumReq-1:0]      req_data_i,
  input  cust_addr_t [NumReq-1:0]      req_addr_i,
  output logic                         out_valid_o,
  output cust_data_t                   out_data_o,
  output cust_addr_t                   out_addr_o,
  input  logic                         out_ready_i,
  input  logic                         in_valid_i,
  input  cust_data_t                   in_data_i,
  input  cust_addr_t                   in_addr_i,
  output logic [NumReq-1:0]            rsp_valid_o,
  output cust_data_t                   rsp_data_o,
  output cust_addr_t                   rsp_addr_o,
  output logic [CustNumAddr-1:0]       pend_o,
  output logic                         err_unsol_o
);

  localparam int IdxW = $clog2(NumReq);

  logic [NumReq-1:0]      eligible;
  logic [NumReq-1:0]      gnt;
  logic [IdxW-1:0]        gnt_idx;
  logic                   gnt_valid;
  logic                   gnt_fire;
  logic                   grant_ok;
  logic                   rsp_hit;
  logic                   rsp_miss;
  cust_addr_t             sel_addr;
  cust_data_t             sel_data;
  logic [CustNumAddr-1:0] set_vec;
  logic [CustNumAddr-1:0] clr_vec;

  logic                   out_valid_reg;
  cust_data_t             out_data_reg;
  cust_addr_t             out_addr_reg;
  logic [NumReq-1:0]      rsp_valid_reg;
  cust_data_t             rsp_data_reg;
  cust_addr_t             rsp_addr_reg;
  logic [CustNumAddr-1:0] pend_reg;
  logic                   err_unsol_reg;
  logic [IdxW-1:0]        ptr_reg;
  logic [IdxW-1:0]        owner_reg [CustNumAddr];

  // A requester is held off while its target address still awaits a response.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_elig
    assign eligible[gi] = req_valid_i[gi] & ~pend_reg[req_addr_i[gi]];
  end

  ibex_cust_rr_arb #(.NumReq(NumReq)) u_rr_arb (
    .eligible  (eligible),
    .ptr       (ptr_reg),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign grant_ok    = ~out_valid_reg | out_ready_i;
  assign gnt_fire    = gnt_valid & grant_ok & ~rst_i;
  assign req_ready_o = gnt_fire ? gnt : '0;
  assign sel_addr    = req_addr_i[gnt_idx];
  assign sel_data    = req_data_i[gnt_idx];
  assign rsp_hit     = in_valid_i & pend_reg[in_addr_i];
  assign rsp_miss    = in_valid_i & ~pend_reg[in_addr_i];

  // Set and clear never target the same address: a grant needs the bit clear,
  // a response hit needs it set.
  for (genvar gi = 0; gi < CustNumAddr; gi++) begin : g_pend_dec
    assign set_vec[gi] = gnt_fire & (sel_addr == cust_addr_t'(gi));
    assign clr_vec[gi] = rsp_hit  & (in_addr_i == cust_addr_t'(gi));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_addr_reg  <= '0;
      ptr_reg       <= '0;
    end else if (gnt_fire) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= sel_data;
      out_addr_reg  <= sel_addr;
      ptr_reg       <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready_i) begin
      out_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_reg <= '0;
      for (int a = 0; a < CustNumAddr; a++) owner_reg[a] <= '0;
    end else begin
      pend_reg <= (pend_reg & ~clr_vec) | set_vec;
      for (int a = 0; a < CustNumAddr; a++) begin
        if (set_vec[a]) owner_reg[a] <= gnt_idx;
      end
    end
  end

  // Response payload only updates on a hit so it holds between pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_addr_reg  <= '0;
      err_unsol_reg <= 1'b0;
    end else begin
      rsp_valid_reg <= rsp_hit ? (NumReq'(1) << owner_reg[in_addr_i]) : '0;
      err_unsol_reg <= rsp_miss;
      if (rsp_hit) begin
        rsp_data_reg <= in_data_i;
        rsp_addr_reg <= in_addr_i;
      end
    end
  end

  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_data_reg;
  assign out_addr_o  = out_addr_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_data_o  = rsp_data_reg;
  assign rsp_addr_o  = rsp_addr_reg;
  assign pend_o      = pend_reg;
  assign err_unsol_o = err_unsol_reg;

endmodule

// File: tb/tb_ibex_cust_io_arb.sv
// Bench for ibex_cust_io_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_ibex_cust_io_arb;

  localparam int N = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0][31:0] req_data;
  logic [N-1:0][4:0]  req_addr;
  logic              out_valid;
  logic [31:0]       out_data;
  logic [4:0]        out_addr;
  logic              out_ready;
  logic              in_valid;
  logic [31:0]       in_data;
  logic [4:0]        in_addr;
  logic [N-1:0]      rsp_valid;
  logic [31:0]       rsp_data;
  logic [4:0]        rsp_addr;
  logic [31:0]       pend;
  logic              err_unsol;

  ibex_cust_io_arb #(.NumReq(N)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .req_addr_i  (req_addr),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_addr_o  (out_addr),
    .out_ready_i (out_ready),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_addr_i   (in_addr),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_addr_o  (rsp_addr),
    .pend_o      (pend),
    .err_unsol_o (err_unsol)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_fail = 0;

  // Transaction-level model: outstanding set, owners, rotating priority, held output.
  bit          m_pend [32];
  int          m_owner [32];
  int          m_ptr;
  bit          m_out_valid;
  logic [31:0] m_out_data;
  logic [4:0]  m_out_addr;
  logic [N-1:0] m_rsp_valid;
  logic [31:0] m_rsp_data;
  logic [4:0]  m_rsp_addr;
  bit          m_err;

  logic [N-1:0] obs_ready;
  logic         obs_out_valid;
  logic [31:0]  obs_out_data;
  logic [N-1:0] obs_rsp_valid;
  logic [31:0]  obs_rsp_data;
  logic [31:0]  obs_pend;
  logic         obs_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 32; a++) begin
      m_pend[a]  = 1'b0;
      m_owner[a] = 0;
    end
    m_ptr = 0; m_out_valid = 0; m_out_data = '0; m_out_addr = '0;
    m_rsp_valid = '0; m_rsp_data = '0; m_rsp_addr = '0; m_err = 0;
  endtask

  task automatic idle();
    req_valid = '0; req_data = '0; req_addr = '0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0;
  endtask

  // Called just after a falling edge with inputs applied; checks, advances the model, moves to next falling edge.
  task automatic step();
    int g;
    logic [N-1:0] exp_ready;
    logic [31:0] pv;
    #1;
    g = -1;
    if (!m_out_valid || out_ready) begin
      for (int i = 0; i < N; i++) begin
        if (g < 0 && req_valid[(m_ptr + i) % N] && !m_pend[req_addr[(m_ptr + i) % N]])
          g = (m_ptr + i) % N;
      end
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    for (int a = 0; a < 32; a++) pv[a] = m_pend[a];

    obs_ready = req_ready; obs_out_valid = out_valid; obs_out_data = out_data;
    obs_rsp_valid = rsp_valid; obs_rsp_data = rsp_data; obs_pend = pend; obs_err = err_unsol;

    chk("req_ready", req_ready, exp_ready);
    chk("out_valid", out_valid, m_out_valid);
    if (m_out_valid) begin
      chk("out_data", out_data, m_out_data);
      chk("out_addr", out_addr, m_out_addr);
    end
    chk("rsp_valid", rsp_valid, m_rsp_valid);
    chk("rsp_data", rsp_data, m_rsp_data);
    chk("rsp_addr", rsp_addr, m_rsp_addr);
    chk("pend", pend, pv);
    chk("err_unsol", err_unsol, m_err);

    if (in_valid && m_pend[in_addr]) begin
      m_rsp_valid = N'(1 << m_owner[in_addr]);
      m_rsp_data = in_data; m_rsp_addr = in_addr;
      m_pend[in_addr] = 1'b0; m_err = 0;
    end else begin
      m_rsp_valid = '0;
      m_err = in_valid;
    end
    if (g >= 0) begin
      m_out_valid = 1; m_out_data = req_data[g]; m_out_addr = req_addr[g];
      m_pend[req_addr[g]] = 1'b1; m_owner[req_addr[g]] = g;
      m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_out_valid = 0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Asserts reset mid-cycle with requests pending; outputs must drop at once.
  task automatic do_reset();
    req_valid = '1;
    #2 rst_i = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_pend", pend, 0);
    chk("rst_err", err_unsol, 0);
    chk("rst_req_ready", req_ready, 0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle();
  endtask

  int cnt;

  initial begin
    idle();
    model_reset();
    @(negedge clk_i);
    do_reset();

    // Four requesters on distinct addresses: strict rotation then nothing left.
    out_ready = 1'b1; req_valid = 4'hF;
    for (int k = 0; k < N; k++) begin
      req_addr[k] = 5'(k + 1);
      req_data[k] = 32'h1000 + k;
    end
    for (int c = 0; c < 5; c++) begin
      step();
      chk("rr_order", obs_ready, (c < 4) ? (64'd1 << c) : 64'd0);
    end
    chk("rr_pend", obs_pend, 32'h1E);

    // Back-pressure: output holds and the single grant is not repeated.
    do_reset();
    req_valid = 4'b0010; req_addr[1] = 5'd5; req_data[1] = 32'hA5A5_0033;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      out_ready = (c >= 4);
      step();
      cnt += int'(obs_ready[1]);
      if (c >= 1 && c <= 3) chk("hold_data", {obs_out_valid, obs_out_data}, {1'b1, 32'hA5A5_0033});
    end
    chk("hold_grants", cnt, 1);

    // Address conflict released by a response.
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b0100; req_addr[2] = 5'd7; req_data[2] = 32'h2222_0007;
    step();
    req_valid = 4'b0001; req_addr[0] = 5'd7; req_data[0] = 32'h0000_0707;
    step(); chk("blk_ready0", obs_ready, 0);
    step(); chk("blk_ready1", obs_ready, 0);
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'hDEADBEEF;
    step(); chk("blk_ready2", obs_ready, 0);
    in_valid = 1'b0;
    step();
    chk("rsp_owner", obs_rsp_valid, 4'b0100);
    chk("rsp_payload", obs_rsp_data, 32'hDEADBEEF);
    chk("regrant", obs_ready, 4'b0001);

    // Unsolicited response.
    do_reset();
    in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h9;
    step();
    in_valid = 1'b0;
    step();
    chk("unsol_err", obs_err, 1);
    chk("unsol_rsp", obs_rsp_valid, 0);
    step();
    chk("unsol_pulse", obs_err, 0);

    // Set and clear of different addresses on the same edge.
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b0001; req_addr[0] = 5'd4;
    step();
    req_valid = 4'b0010; req_addr[1] = 5'd3;
    in_valid = 1'b1; in_addr = 5'd4; in_data = 32'h44;
    step();
    chk("sc_ready", obs_ready, 4'b0010);
    idle();
    step();
    chk("sc_bit3", obs_pend[3], 1);
    chk("sc_bit4", obs_pend[4], 0);

    // Reset with an output held and two outstanding addresses.
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b0011; req_addr[0] = 5'd0; req_addr[1] = 5'd1;
    step();
    step();
    out_ready = 1'b0;
    step();
    chk("pre_rst_pend", obs_pend, 32'h3);
    chk("pre_rst_valid", obs_out_valid, 1);
    do_reset();
    in_valid = 1'b1; in_addr = 5'd0;
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst_unsol", obs_err, 1);

    // Random traffic on a small address range to force conflicts.
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < N; k++) begin
        req_valid[k] = ($urandom_range(0, 2) != 0);
        req_addr[k]  = 5'($urandom_range(0, 7));
        req_data[k]  = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) == 0);
      in_addr   = 5'($urandom_range(0, 7));
      in_data   = $urandom;
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_cust_io_arb.md
IBEX_CUST_IO_ARB -- requirements
Module: ibex_cust_io_arb

Interface
REQ-001 Parameter NumReq, default 4, number of requesters sharing the custom I/O channel (2..8).
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  input  NumReq  per-requester write request valid.
REQ-005 req_ready_o  output  NumReq  per-requester grant; at most one bit set per cycle.
REQ-006 req_data_i  input  NumReq x 32  per-requester payload.
REQ-007 req_addr_i  input  NumReq x 5  per-requester custom register address.
REQ-008 out_valid_o, out_data_o, out_addr_o  output  1/32/5  granted request toward the core's custom input channel.
REQ-009 out_ready_i  input  1  downstream accepts out_* when high with out_valid_o.
REQ-010 in_valid_i, in_data_i, in_addr_i  input  1/32/5  response from the core's custom output channel.
REQ-011 rsp_valid_o  output  NumReq  one-cycle response pulse to owning requester.
REQ-012 rsp_data_o, rsp_addr_o  output  32/5  shared response payload, valid with any rsp_valid_o bit.
REQ-013 pend_o  output  32  per-address outstanding bitmap.
REQ-014 err_unsol_o  output  1  one-cycle pulse on an unsolicited response.

Function
REQ-015 Requester k is eligible when req_valid_i[k]=1 and pend_o[req_addr_i[k]]=0.
REQ-016 Grant permitted when out_valid_o=0 or (out_valid_o and out_ready_i) in the same cycle.
REQ-017 Round-robin: search starts at pointer ptr and increments mod NumReq; first eligible k wins; ptr becomes (k+1) mod NumReq after a grant, unchanged otherwise.
REQ-018 req_ready_o[k] is combinational, high only in the grant cycle; the request transfers on that edge.
REQ-019 Latency: grant in cycle N gives out_valid_o=1 with the granted data/addr in cycle N+1.
REQ-020 out_* hold stable while out_valid_o=1 and out_ready_i=0; out_valid_o clears after acceptance with no new grant.
REQ-021 On grant: pend[addr] set and owner[addr]=k (owner table 32 x clog2(NumReq)).
REQ-022 in_valid_i with pend[in_addr_i]=1: next cycle rsp_valid_o[owner]=1, rsp_data_o/rsp_addr_o registered from in_*, pend cleared.
REQ-023 in_valid_i with pend[in_addr_i]=0: next cycle err_unsol_o=1, rsp_valid_o=0, state unchanged.
REQ-024 Same-cycle set and clear on different addresses both take effect; same address is impossible per REQ-015.
REQ-025 A response accepted for an address whose request is still held in out_* is processed normally.
REQ-026 rsp_data_o/rsp_addr_o hold their last value when rsp_valid_o=0.

Reset
REQ-027 Asserting rst_i clears out_valid_o, out_data_o, out_addr_o, rsp_valid_o, rsp_data_o, rsp_addr_o, pend_o, err_unsol_o, the owner table and ptr to 0 immediately.
REQ-028 Reset mid-transfer drops the held request and all outstanding responses; responses arriving after reset release are reported unsolicited.
REQ-029 req_ready_o=0 while rst_i=1.

Structure
REQ-030 ibex_pkg holds typedef cust_addr_t (5 bits), cust_data_t (32 bits) and constant CustNumAddr=32.
REQ-031 Round-robin selection is a sub-module ibex_cust_rr_arb (inputs eligible vector, ptr; outputs one-hot grant, grant index).

Verification
REQ-032 Requesters 0..3 valid every cycle at addresses 1..4, out_ready_i=1, no responses: grants in order 0,1,2,3, then none; pend_o=0x1E.
REQ-033 Req1 to addr 5, out_ready_i low for 3 cycles: out_data_o stable 3 cycles, req_ready_o[1] high exactly once, no other grant.
REQ-034 Req2 holds addr 7 pending, req0 requests addr 7: no grant until in_valid_i addr 7 data 0xDEADBEEF; then rsp_valid_o[2]=1 with rsp_data_o=0xDEADBEEF, req0 granted next cycle.
REQ-035 in_valid_i at addr 9 with pend_o=0: err_unsol_o pulse one cycle, rsp_valid_o=0.
REQ-036 Grant to addr 3 and response for addr 4 in the same cycle: pend_o bit 3 set, bit 4 cleared next cycle.
REQ-037 rst_i asserted with out_valid_o=1 and pend_o=0x3: all outputs zero immediately; the later response at addr 0 gives err_unsol_o.
